// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM.
// Optional feature macro: MC_IMM_LOGIC_EN adds andi/ori (zero-extended
// immediate logic ops) to the instruction set; without it they are illegal.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

`ifdef MC_IMM_LOGIC_EN
  localparam logic IMM_LOGIC_EN = 1'b1;
`else
  localparam logic IMM_LOGIC_EN = 1'b0;
`endif

  // True for andi/ori when the immediate-logic extension is built in.
  function automatic logic is_imm_logic(input logic [5:0] op);
    return IMM_LOGIC_EN && ((op == OP_ANDI) || (op == OP_ORI));
  endfunction

  // Opcodes that DECODE dispatches somewhere other than back to FETCH.
  function automatic logic opcode_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW) ||
           is_imm_logic(op);
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode: maps (state, opcode, funct) to the ALU control code
// and flags an unsupported funct while executing an R-type instruction.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  state_t     state_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_control_o,
  output logic       funct_illegal_o
);

  // Per-state ALU operation; states that do not use the ALU drive 000.
  always_comb begin
    alu_control_o   = 3'b000;
    funct_illegal_o = 1'b0;
    case (state_i)
      S_FETCH, S_DECODE, S_MEMADR: alu_control_o = ALU_ADD;
      S_BRANCH: alu_control_o = ALU_SUB;
      S_IMMEX: begin
        if (is_imm_logic(opcode_i)) begin
          alu_control_o = (opcode_i == OP_ORI) ? ALU_OR : ALU_AND;
        end else begin
          alu_control_o = ALU_ADD;
        end
      end
      S_EXEC: begin
        case (funct_i)
          FN_ADD:  alu_control_o = ALU_ADD;
          FN_SUB:  alu_control_o = ALU_SUB;
          FN_AND:  alu_control_o = ALU_AND;
          FN_OR:   alu_control_o = ALU_OR;
          FN_SLT:  alu_control_o = ALU_SLT;
          default: funct_illegal_o = 1'b1;
        endcase
      end
      default: alu_control_o = 3'b000;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/
// writeback and drives every datapath enable and mux select.
// Optional feature macro: MC_IMM_LOGIC_EN (andi/ori via IMMEX/IMMWB).
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       iord,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] pc_src,
  output logic       ext_zero,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q, state_d;
  logic   funct_illegal;

  alu_decoder u_alu_decoder (
    .state_i         (state_q),
    .opcode_i        (opcode),
    .funct_i         (funct),
    .alu_control_o   (alu_control),
    .funct_illegal_o (funct_illegal)
  );

  assign state = state_q;

  // State register; reset aborts any instruction and returns to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic; memory states wait on mem_ready, others advance.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if ((opcode == OP_LW) || (opcode == OP_SW)) state_d = S_MEMADR;
        else if (opcode == OP_RTYPE)                state_d = S_EXEC;
        else if (opcode == OP_BEQ)                  state_d = S_BRANCH;
        else if ((opcode == OP_ADDI) || is_imm_logic(opcode)) state_d = S_IMMEX;
        else if (opcode == OP_J)                    state_d = S_JUMP;
        else                                        state_d = S_FETCH;
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = funct_illegal ? S_FETCH : S_ALUWB;
      S_IMMEX:  state_d = S_IMMWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode: Moore selects, plus the mem_ready/zero-qualified PC
  // enable and the illegal-op pulse; enables are held low during reset.
  always_comb begin
    pc_en      = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    iord       = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    pc_src     = PCSRC_ALU;
    ext_zero   = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_IMM_SH;
        illegal_op = ~opcode_legal(opcode);
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        illegal_op = funct_illegal;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        pc_src    = PCSRC_ALUOUT;
        pc_en     = zero;
      end
      S_IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_zero  = is_imm_logic(opcode);
      end
      S_IMMWB: begin
        reg_write = 1'b1;
        ext_zero  = is_imm_logic(opcode);
      end
      S_JUMP: begin
        pc_src = PCSRC_JUMP;
        pc_en  = 1'b1;
      end
      default: pc_en = 1'b0;
    endcase
    if (reset) begin
      pc_en      = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: builds a per-cycle expected trace
// for each instruction from the instruction-level behaviour and compares
// every output each cycle.
module tb_multicycle_controller;

  logic       clk, reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_en, ir_write, mem_write, reg_write, iord, mem_to_reg;
  logic       reg_dst, alu_src_a, ext_zero, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .ir_write(ir_write),
    .mem_write(mem_write), .reg_write(reg_write), .iord(iord),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .pc_src(pc_src),
    .ext_zero(ext_zero), .illegal_op(illegal_op), .state(state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic pc_en, ir_write, mem_write, reg_write, iord, mem_to_reg, reg_dst, alu_src_a;
    logic [1:0] src_b;
    logic [2:0] alu;
    logic [1:0] pc_src;
    logic ext_zero, illegal;
  } obs_t;

  typedef struct packed {
    logic mr;
    logic zr;
    logic [5:0] op;
    logic [5:0] fn;
  } stim_t;

`ifdef MC_IMM_LOGIC_EN
  localparam bit IMM_LOGIC = 1'b1;
`else
  localparam bit IMM_LOGIC = 1'b0;
`endif

  logic [20:0] exp_q[$];
  stim_t       stim_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic obs_t mk(input logic [3:0] st);
    obs_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic obs_t fetch_vals();
    obs_t o;
    o = mk(4'd0);
    o.src_b = 2'b01;
    o.alu = 3'b010;
    return o;
  endfunction

  // ALU code for an R-type funct; -1 marks an unsupported funct.
  function automatic int alu_for_funct(input logic [5:0] fn);
    case (fn)
      6'h20: return 2;
      6'h22: return 6;
      6'h24: return 0;
      6'h25: return 1;
      6'h2A: return 7;
      default: return -1;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input obs_t o, input logic mr, input logic zr,
                      input logic [5:0] op, input logic [5:0] fn);
    stim_t s;
    s.mr = mr; s.zr = zr; s.op = op; s.fn = fn;
    exp_q.push_back(o);
    stim_q.push_back(s);
  endtask

  // Reference model: expected cycle-by-cycle trace of one instruction.
  // fs = FETCH cycles with memory not ready, ms = MEMRD/MEMWR wait cycles.
  task automatic build_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic zr, input int fs, input int ms);
    obs_t o;
    int   a;
    bit   imm_logic;
    imm_logic = IMM_LOGIC && (op == 6'h0C || op == 6'h0D);
    for (int i = 0; i < fs; i++) push(fetch_vals(), 1'b0, rbit(), 6'($urandom), 6'($urandom));
    o = fetch_vals(); o.pc_en = 1'b1; o.ir_write = 1'b1;
    push(o, 1'b1, rbit(), 6'($urandom), 6'($urandom));
    o = mk(4'd1); o.src_b = 2'b11; o.alu = 3'b010;
    o.illegal = !(op == 6'h00 || op == 6'h02 || op == 6'h04 || op == 6'h08 ||
                  op == 6'h23 || op == 6'h2B || imm_logic);
    push(o, rbit(), rbit(), op, fn);
    if (op == 6'h23 || op == 6'h2B) begin
      o = mk(4'd2); o.alu_src_a = 1'b1; o.src_b = 2'b10; o.alu = 3'b010;
      push(o, rbit(), rbit(), op, fn);
      o = (op == 6'h23) ? mk(4'd3) : mk(4'd5);
      o.iord = 1'b1;
      o.mem_write = (op == 6'h2B);
      for (int i = 0; i < ms; i++) push(o, 1'b0, rbit(), op, fn);
      push(o, 1'b1, rbit(), op, fn);
      if (op == 6'h23) begin
        o = mk(4'd4); o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
        push(o, rbit(), rbit(), op, fn);
      end
    end else if (op == 6'h00) begin
      a = alu_for_funct(fn);
      o = mk(4'd6); o.alu_src_a = 1'b1;
      o.alu = (a < 0) ? 3'b000 : 3'(a);
      o.illegal = (a < 0);
      push(o, rbit(), rbit(), op, fn);
      if (a >= 0) begin
        o = mk(4'd7); o.reg_write = 1'b1; o.reg_dst = 1'b1;
        push(o, rbit(), rbit(), op, fn);
      end
    end else if (op == 6'h04) begin
      o = mk(4'd8); o.alu_src_a = 1'b1; o.alu = 3'b110; o.pc_src = 2'b01; o.pc_en = zr;
      push(o, rbit(), zr, op, fn);
    end else if (op == 6'h08 || imm_logic) begin
      o = mk(4'd9); o.alu_src_a = 1'b1; o.src_b = 2'b10;
      o.alu = (op == 6'h0C && imm_logic) ? 3'b000 : (op == 6'h0D && imm_logic) ? 3'b001 : 3'b010;
      o.ext_zero = imm_logic;
      push(o, rbit(), rbit(), op, fn);
      o = mk(4'd10); o.reg_write = 1'b1; o.ext_zero = imm_logic;
      push(o, rbit(), rbit(), op, fn);
    end else if (op == 6'h02) begin
      o = mk(4'd11); o.pc_src = 2'b10; o.pc_en = 1'b1;
      push(o, rbit(), rbit(), op, fn);
    end
  endtask

  function automatic logic [20:0] observe();
    return {state, pc_en, ir_write, mem_write, reg_write, iord, mem_to_reg, reg_dst,
            alu_src_a, alu_src_b, alu_control, pc_src, ext_zero, illegal_op};
  endfunction

  // Driver + scoreboard: call just after a rising edge with the DUT in FETCH.
  task automatic run_trace(input string tag, input int limit);
    stim_t       s;
    logic [20:0] e, act;
    int          n;
    n = 0;
    while (exp_q.size() > 0 && (limit < 0 || n < limit)) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      mem_ready = s.mr; zero = s.zr; opcode = s.op; funct = s.fn;
      @(negedge clk);
      act = observe();
      n_checks++;
      if (act !== e)
        $display("FAIL %s cycle %0d: state=%0d outputs=%h expected state=%0d outputs=%h",
                 tag, n, act[20:17], act, e[20:17], e);
      else n_pass++;
      @(posedge clk); #1;
      n++;
    end
    exp_q.delete();
    stim_q.delete();
  endtask

  task automatic test_reset();
    logic [20:0] act;
    reset = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = 6'h00; funct = 6'h00;
    #1 reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      act = observe();
      n_checks++;
      if (act !== 21'(fetch_vals()))
        $display("FAIL reset_hold: outputs=%h expected=%h", act, 21'(fetch_vals()));
      else n_pass++;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    build_instr(6'h02, 6'h00, 1'b0, 0, 0);
    run_trace("first_fetch_j", -1);
  endtask

  task automatic test_rtype_sub();
    build_instr(6'h00, 6'h22, 1'b0, 0, 0);
    run_trace("rtype_sub", -1);
  endtask

  task automatic test_lw_stall();
    build_instr(6'h23, 6'($urandom), 1'b0, 0, 2);
    run_trace("lw_stall", -1);
  endtask

  task automatic test_sw_stall();
    build_instr(6'h2B, 6'($urandom), 1'b1, 2, 3);
    run_trace("sw_stall", -1);
  endtask

  task automatic test_beq();
    build_instr(6'h04, 6'($urandom), 1'b1, 0, 0);
    run_trace("beq_taken", -1);
    build_instr(6'h04, 6'($urandom), 1'b0, 1, 0);
    run_trace("beq_not_taken", -1);
  endtask

  task automatic test_illegal();
    build_instr(6'h3F, 6'h20, 1'b0, 0, 0);
    run_trace("illegal_op", -1);
    build_instr(6'h00, 6'h3F, 1'b0, 0, 0);
    run_trace("illegal_funct", -1);
  endtask

  task automatic test_imm_logic();
    build_instr(6'h0D, 6'($urandom), 1'b0, 0, 0);
    run_trace("ori", -1);
    build_instr(6'h0C, 6'($urandom), 1'b0, 0, 0);
    run_trace("andi", -1);
    build_instr(6'h08, 6'($urandom), 1'b0, 0, 0);
    run_trace("addi", -1);
  endtask

  // Reset asserted in MEMWB must suppress the writeback at once.
  task automatic test_reset_abort();
    logic [20:0] act;
    build_instr(6'h23, 6'h00, 1'b0, 0, 0);
    run_trace("abort_lw_prefix", 4);
    mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    act = observe();
    n_checks++;
    if (act !== 21'(fetch_vals()))
      $display("FAIL reset_abort: outputs=%h expected=%h", act, 21'(fetch_vals()));
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    build_instr(6'h00, 6'h25, 1'b0, 0, 0);
    run_trace("after_abort", -1);
  endtask

  task automatic test_random();
    logic [5:0] ops[9];
    logic [5:0] fns[6];
    logic [5:0] op, fn;
    ops = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h00};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
    for (int i = 0; i < 150; i++) begin
      op = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      fn = fns[$urandom_range(0, 5)];
      if (fn == 6'h00) fn = 6'($urandom);
      build_instr(op, fn, rbit(), $urandom_range(0, 3), $urandom_range(0, 3));
      run_trace("random", -1);
    end
  endtask

  initial begin
    test_reset();
    test_rtype_sub();
    test_lw_stall();
    test_sw_stall();
    test_beq();
    test_illegal();
    test_imm_logic();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multi-cycle MIPS datapath. Each instruction is sequenced through fetch, decode, execute, memory and writeback steps. The block drives every write enable and mux select in the datapath, including the immediate-extension mode feeding the ALU B-mux, and the ALU operation code. It stalls on a single memory-ready handshake.

## Interface
Parameters:
- none; all encodings are constants in the shared package.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; forces state to FETCH.
- `opcode`  in  6  IR[31:26], valid from DECODE onward.
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_en`  out  1  PC load: fetch increment, jump, or taken beq.
- `ir_write`  out  1  IR load.
- `mem_write`  out  1  memory write strobe.
- `reg_write`  out  1  register file write.
- `iord`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `mem_to_reg`  out  1  writeback data: 0 = ALUOut, 1 = MDR.
- `reg_dst`  out  1  destination register: 0 = rt, 1 = rd.
- `alu_src_a`  out  1  ALU A input: 0 = PC, 1 = A.
- `alu_src_b`  out  2  ALU B input: 00 = B, 01 = 4, 10 = ext_imm, 11 = ext_imm<<2.
- `alu_control`  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `pc_src`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ext_zero`  out  1  1 = zero-extend the immediate, 0 = sign-extend.
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode or funct.
- `state`  out  4  current state, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, IMMEX 9, IMMWB 10, JUMP 11. Codes 12–15 are unreachable and return to FETCH.
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, add, pc_src=00.
  - With mem_ready=1: ir_write=1, pc_en=1, go to DECODE.
  - With mem_ready=0: stay in FETCH, no enables.
- DECODE: alu_src_a=0, alu_src_b=11, add (precomputes the branch target). Dispatch on opcode:
  - 0x23 lw and 0x2B sw → MEMADR.
  - 0x00 R-type → EXEC.
  - 0x04 beq → BRANCH.
  - 0x08 addi → IMMEX.
  - 0x02 j → JUMP.
  - Anything else → FETCH, with illegal_op=1.
- MEMADR: alu_src_a=1, alu_src_b=10, add. lw → MEMRD, sw → MEMWR.
- MEMRD: iord=1. Wait in MEMRD until mem_ready=1, then go to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
- MEMWR: iord=1, mem_write=1, held asserted until mem_ready=1 → FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_control from the funct decode:
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
  - Any other funct → FETCH with illegal_op=1 (nothing is written).
  - Otherwise → ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_en=zero → FETCH.
- IMMEX: alu_src_a=1, alu_src_b=10, add, ext_zero=0 → IMMWB.
- IMMWB: reg_write=1, reg_dst=0 → FETCH.
- JUMP: pc_src=10, pc_en=1 → FETCH.
- All unlisted outputs are 0 in every state.

## Timing
- Outputs are Moore, decoded from state, with two exceptions:
  - pc_en in FETCH depends on mem_ready; in BRANCH it depends on zero (combinational).
  - illegal_op is combinational in DECODE/EXEC.
- Instruction latencies with mem_ready=1 continuously:
  - lw 5 cycles; sw, R-type and addi 4; beq and j 3.
  - Each cycle with mem_ready low adds one cycle in FETCH, MEMRD or MEMWR.
- While reset is high:
  - state=FETCH.
  - pc_en, ir_write, mem_write, reg_write and illegal_op are forced to 0.
  - Mux selects take their FETCH values.
- Reset asserted mid-instruction aborts it immediately. No partial writeback occurs after reset asserts.
- The first fetch is taken on the first rising edge after reset deasserts on which mem_ready=1.
- mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.

## Configuration
- `MC_IMM_LOGIC_EN` defined:
  - Opcodes 0x0C andi and 0x0D ori dispatch from DECODE to IMMEX.
  - In IMMEX for these opcodes: ext_zero=1 and alu_control is and or or, respectively.
  - In IMMWB, ext_zero stays at 1.
- Undefined:
  - 0x0C and 0x0D are illegal.
  - ext_zero is tied to 0.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the state encodings;
  - opcode and funct constants;
  - ALU control codes;
  - alu_src_b and pc_src select encodings.
- Sub-module `alu_decoder` maps (state, opcode, funct) to {alu_control, funct_illegal}.
- The FSM register, next-state logic and output decode stay in `multicycle_controller`.

## Test plan
- Reset held for 3 cycles with mem_ready=1, then released:
  - state=0 and all enables 0 during reset;
  - ir_write=1 and pc_en=1 on the first post-reset cycle.
- R-type funct=0x22, mem_ready=1:
  - states 0,1,6,7 in sequence;
  - alu_control=110 in EXEC;
  - reg_write=1 with reg_dst=1 in ALUWB only.
- lw with mem_ready low for 2 cycles in MEMRD:
  - states 0,1,2,3,3,3,4;
  - reg_write=1 with mem_to_reg=1 in state 4.
- beq:
  - with zero=1: pc_en=1, pc_src=01 in BRANCH;
  - with zero=0: pc_en=0, and the next state is FETCH.
- opcode 0x3F in DECODE:
  - illegal_op=1 for one cycle, next state FETCH, no write enables asserted.
- With `MC_IMM_LOGIC_EN`, ori (0x0D):
  - IMMEX has ext_zero=1 and alu_control=001;
  - IMMWB has reg_write=1.
- Without the macro, the same ori input gives illegal_op=1.
